// File: rtl/viterbi_frame_sched.sv
// Frame scheduler for the radix-4 Viterbi datapath.
// One frame is: path-metric clear, FRAME_LEN forward steps through the
// extract/branch/add/survivor-write pipeline, then a traceback over the
// survivor memory from the last address down to 0.
module viterbi_frame_sched #(
    parameter int FRAME_LEN = 8,
    parameter int ADDR_W    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              en_c,
    output logic              en_extract,
    output logic              en_branch,
    output logic              en_add,
    output logic              en_memory,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              en_traceback,
    output logic              tb_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {IDLE, CLEAR, FWD, DRAIN, TB, DONE} state_t;

    localparam int                STAGES = 2;
    // Counters saturate here instead of reaching FRAME_LEN, which may not
    // fit in ADDR_W bits.
    localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(FRAME_LEN - 1);

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   acc_cnt, wr_cnt, rd_cnt;
    // vld_pipe[1]: symbol in branch stage; vld_pipe[2]: symbol in add/write stage
    logic [STAGES:1]     vld_pipe;
    logic                accept, wr_act;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state and strobe decode; every strobe is qualified by en
    always_comb begin
        state_nxt    = state;
        in_ready     = 1'b0;
        en_c         = 1'b0;
        en_extract   = 1'b0;
        en_branch    = 1'b0;
        en_add       = 1'b0;
        en_memory    = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        en_traceback = 1'b0;
        tb_last      = 1'b0;
        done         = 1'b0;
        busy         = (state != IDLE);
        accept       = 1'b0;
        wr_act       = 1'b0;
        case (state)
            IDLE: begin
                if (en && start) state_nxt = CLEAR;
            end
            CLEAR: begin
                en_c = en;
                if (en) state_nxt = FWD;
            end
            FWD: begin
                in_ready  = en;
                accept    = en && in_valid;
                en_branch = en && vld_pipe[1];
                wr_act    = en && vld_pipe[2];
                if (accept && acc_cnt == LAST) state_nxt = DRAIN;
            end
            DRAIN: begin
                en_branch = en && vld_pipe[1];
                wr_act    = en && vld_pipe[2];
                // Branch stage empty means the write stage empties on this edge
                if (en && !vld_pipe[1]) state_nxt = TB;
            end
            TB: begin
                en_traceback = en;
                en_memory    = en;
                mem_addr     = rd_cnt;
                tb_last      = en && (rd_cnt == '0);
                if (en && rd_cnt == '0) state_nxt = DONE;
            end
            DONE: begin
                done = en;
                if (en) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        en_extract = accept;
        en_add     = wr_act;
        mem_we     = wr_act;
        if (wr_act) begin
            en_memory = 1'b1;
            mem_addr  = wr_cnt;
        end
    end

    // Pipeline valid shift and frame counters; all frozen while en=0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe <= '0;
            acc_cnt  <= '0;
            wr_cnt   <= '0;
            rd_cnt   <= '0;
        end else if (en) begin
            if (state == DONE) begin
                vld_pipe <= '0;
                acc_cnt  <= '0;
                wr_cnt   <= '0;
                rd_cnt   <= '0;
            end else begin
                if (state == FWD || state == DRAIN)
                    vld_pipe <= {vld_pipe[1], accept};
                if (accept && acc_cnt != LAST)
                    acc_cnt <= acc_cnt + 1'b1;
                if (wr_act && wr_cnt != LAST)
                    wr_cnt <= wr_cnt + 1'b1;
                if (state == DRAIN && state_nxt == TB)
                    rd_cnt <= LAST;
                else if (state == TB && rd_cnt != '0)
                    rd_cnt <= rd_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_viterbi_frame_sched.sv
// Bench for viterbi_frame_sched: directed frame scenarios plus random
// start/in_valid/en traffic, checked cycle by cycle against an
// event-queue model of the frame schedule.
module tb_viterbi_frame_sched;

    localparam int FL = 8;
    localparam int AW = 3;

    logic          clk, rst, en, start, in_valid;
    logic          in_ready, en_c, en_extract, en_branch, en_add, en_memory, mem_we;
    logic [AW-1:0] mem_addr;
    logic          en_traceback, tb_last, busy, done;

    int n_chk, n_fail, cyc, done_cyc, clr_cyc;

    viterbi_frame_sched #(.FRAME_LEN(FL), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .en(en), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .en_c(en_c), .en_extract(en_extract),
        .en_branch(en_branch), .en_add(en_add), .en_memory(en_memory),
        .mem_we(mem_we), .mem_addr(mem_addr), .en_traceback(en_traceback),
        .tb_last(tb_last), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Model: phase 0 idle, 1 clear, 2 forward/drain, 3 traceback, 4 done.
    // Forward time counts only enabled cycles; each accept queues its tick,
    // it is in the branch stage one tick later and written two ticks later.
    int m_ph, m_nacc, m_tick, m_wr, m_rd;
    int m_q[$];

    task automatic model_reset();
        m_ph = 0; m_nacc = 0; m_tick = 0; m_wr = 0; m_rd = 0;
        m_q.delete();
    endtask

    task automatic model_step(input logic s, input logic iv, input logic e,
                              output logic [13:0] ex);
        logic rdy, acc, br, wr, c, tbv, last, dn, bsy;
        logic [AW-1:0] a;
        rdy = 0; acc = 0; br = 0; wr = 0; c = 0; tbv = 0; last = 0; dn = 0; a = '0;
        bsy = (m_ph != 0);
        if (e) begin
            case (m_ph)
                0: if (s) m_ph = 1;
                1: begin c = 1; m_ph = 2; end
                2: begin
                    rdy = (m_nacc < FL);
                    acc = rdy && iv;
                    br  = (m_q.size() > 0) && (m_q[m_q.size()-1] == m_tick - 1);
                    wr  = (m_q.size() > 0) && (m_q[0] == m_tick - 2);
                    if (wr) begin
                        a = AW'(m_wr);
                        m_wr++;
                        void'(m_q.pop_front());
                    end
                    if (acc) begin
                        m_q.push_back(m_tick);
                        m_nacc++;
                    end
                    if (m_nacc == FL && m_q.size() == 0) begin
                        m_ph = 3;
                        m_rd = FL - 1;
                    end
                    m_tick++;
                end
                3: begin
                    tbv  = 1;
                    a    = AW'(m_rd);
                    last = (m_rd == 0);
                    if (last) m_ph = 4;
                    else      m_rd--;
                end
                default: begin
                    dn = 1;
                    model_reset();
                end
            endcase
        end else if (m_ph == 3) begin
            a = AW'(m_rd);
        end
        ex = {bsy, dn, last, tbv, a, wr, (wr | tbv), wr, br, acc, c, rdy};
    endtask

    function automatic logic [13:0] outs();
        return {busy, done, tb_last, en_traceback, mem_addr, mem_we, en_memory,
                en_add, en_branch, en_extract, en_c, in_ready};
    endfunction

    task automatic run_cycle(input string tn, input logic s, input logic iv, input logic e);
        logic [13:0] ex;
        start = s; in_valid = iv; en = e;
        @(negedge clk);
        model_step(s, iv, e, ex);
        chk($sformatf("%s_c%0d", tn, cyc), 32'(outs()), 32'(ex));
        if (done) done_cyc = cyc;
        if (en_c) clr_cyc = cyc;
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic pulse_reset(input string tn);
        rst = 1'b0;
        #1;
        chk({tn, "_async"}, 32'(outs()), 32'd0);
        model_reset();
        start = 0; in_valid = 0; en = 1;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    initial begin
        n_chk = 0; n_fail = 0; cyc = 0; done_cyc = -1; clr_cyc = -1;
        start = 0; in_valid = 0; en = 1; rst = 1;
        model_reset();
        #1 rst = 1'b0;
        #1 chk("reset_outs", 32'(outs()), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Idle with no start
        cyc = 0;
        for (int i = 0; i < 20; i++) run_cycle("idle", 0, 1, 1);

        // Clean frame
        cyc = 0; done_cyc = -1;
        for (int i = 0; i < 22; i++) run_cycle("frame", (i == 0), 1, 1);
        chk("frame_done_cyc", done_cyc, 20);

        // in_valid gap at cycles 4 and 5
        cyc = 0; done_cyc = -1;
        for (int i = 0; i < 24; i++) run_cycle("gap", (i == 0), !(i == 4 || i == 5), 1);
        chk("gap_done_cyc", done_cyc, 22);

        // en low during traceback, cycles 14..16
        cyc = 0; done_cyc = -1;
        for (int i = 0; i < 25; i++) run_cycle("hold", (i == 0), 1, !(i >= 14 && i <= 16));
        chk("hold_done_cyc", done_cyc, 23);

        // Reset mid-forward at cycle 7, then a full fresh frame
        cyc = 0;
        for (int i = 0; i < 7; i++) run_cycle("rstmid", (i == 0), 1, 1);
        pulse_reset("rstmid");
        cyc = 0;
        for (int i = 0; i < 3; i++) run_cycle("rstidle", 0, 1, 1);
        cyc = 0; done_cyc = -1;
        for (int i = 0; i < 22; i++) run_cycle("refr", (i == 0), 1, 1);
        chk("refr_done_cyc", done_cyc, 20);

        // start held high: one frame, next clear only after returning to idle
        cyc = 0; done_cyc = -1; clr_cyc = -1;
        for (int i = 0; i < 21; i++) run_cycle("hstart", 1, 1, 1);
        chk("hstart_done_cyc", done_cyc, 20);
        chk("hstart_one_clr", clr_cyc, 1);
        for (int i = 0; i < 2; i++) run_cycle("hstart", 1, 1, 1);
        chk("hstart_clr2_cyc", clr_cyc, 22);
        pulse_reset("hstart");

        // Random traffic
        cyc = 0;
        for (int i = 0; i < 600; i++)
            run_cycle("rnd", ($urandom_range(0, 99) < 25), ($urandom_range(0, 99) < 70),
                      ($urandom_range(0, 99) < 85));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
